// File: rtl/score_digits_controller.sv
`default_nettype none
// ============================================================================
//  Module   : score_digits_controller
//  Purpose  : Converts a binary score to four BCD digits (double dabble) and
//             decodes the VGA pixel position into digit slot/offset for the
//             bitmap renderer.
//  Revision : 1.0 - initial release
// ============================================================================
module score_digits_controller #(
    parameter int TOPLEFT_X     = 16,
    parameter int TOPLEFT_Y     = 8,
    parameter int DIGIT_W       = 32,
    parameter int DIGIT_H       = 64,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] scoreIn,
    input  logic        scoreLoad,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        busy,
    output logic        done,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [3:0]  digit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int          c_w_sh       = $clog2(DIGIT_W);
    localparam logic [3:0]  c_last_shift = 4'd13;
    localparam logic [10:0] c_x_lo       = 11'(TOPLEFT_X);
    localparam logic [11:0] c_x_hi       = 12'(TOPLEFT_X + 4 * DIGIT_W);
    localparam logic [10:0] c_y_lo       = 11'(TOPLEFT_Y);
    localparam logic [11:0] c_y_hi       = 12'(TOPLEFT_Y + DIGIT_H);
    localparam logic [10:0] c_x_mask     = 11'(DIGIT_W - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [29:0]  sr_q, sr_d;
    logic [13:0]  pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
    logic [15:0]  disp_q, disp_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [10:0]  offset_x_q, offset_x_d;
    logic [10:0]  offset_y_q, offset_y_d;
    logic         inside_q, inside_d;
    logic [3:0]   digit_q, digit_d;

    logic [13:0]  w_load_val;
    logic [29:0]  w_adj;
    logic [10:0]  w_dx;
    logic [10:0]  w_dy;
    logic         w_in_rect;
    logic [1:0]   w_slot;
    logic [3:0]   w_digit;
    logic [3:0]   w_lead_zero;
    logic         w_show;

    // Conversion sequencer; register layout is {BCD[29:14], binary[13:0]}
    always_comb begin
        w_load_val = (scoreIn >= 14'd10000) ? 14'd9999 : scoreIn;

        w_adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[14 + 4 * i +: 4] >= 4'd5) begin
                w_adj[14 + 4 * i +: 4] = sr_q[14 + 4 * i +: 4] + 4'd3;
            end
        end

        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scoreLoad) begin
                    sr_d    = {16'd0, w_load_val};
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end else if (pend_valid_q) begin
                    sr_d         = {16'd0, pend_q};
                    pend_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (scoreLoad) begin
                    pend_d       = w_load_val;
                    pend_valid_d = 1'b1;
                end
                sr_d  = w_adj << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_last_shift) begin
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                end
            end
            ST_COMMIT: begin
                disp_d = sr_q[29:14];
                // A load arriving now supersedes any older pending value
                if (scoreLoad) begin
                    sr_d         = {16'd0, w_load_val};
                    pend_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    state_d      = ST_SHIFT;
                end else if (pend_valid_q) begin
                    sr_d         = {16'd0, pend_q};
                    pend_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    state_d      = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Pixel-side decode against the displayed (committed) digits
    always_comb begin
        w_dx      = pixelX - c_x_lo;
        w_dy      = pixelY - c_y_lo;
        w_in_rect = ({1'b0, pixelX} >= {1'b0, c_x_lo}) && ({1'b0, pixelX} < c_x_hi) &&
                    ({1'b0, pixelY} >= {1'b0, c_y_lo}) && ({1'b0, pixelY} < c_y_hi);
        w_slot    = w_dx[c_w_sh +: 2];

        case (w_slot)
            2'd0:    w_digit = disp_q[15:12];
            2'd1:    w_digit = disp_q[11:8];
            2'd2:    w_digit = disp_q[7:4];
            default: w_digit = disp_q[3:0];
        endcase

        w_lead_zero[0] = (disp_q[15:12] == 4'd0);
        w_lead_zero[1] = w_lead_zero[0] && (disp_q[11:8] == 4'd0);
        w_lead_zero[2] = w_lead_zero[1] && (disp_q[7:4] == 4'd0);
        w_lead_zero[3] = 1'b0;

        w_show = w_in_rect && !((BLANK_LEADING != 0) && w_lead_zero[w_slot]);

        inside_d   = w_show;
        offset_x_d = w_show ? (w_dx & c_x_mask) : 11'd0;
        offset_y_d = w_show ? w_dy : 11'd0;
        digit_d    = w_show ? w_digit : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            sr_q         <= 30'd0;
            pend_q       <= 14'd0;
            pend_valid_q <= 1'b0;
            disp_q       <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            offset_x_q   <= 11'd0;
            offset_y_q   <= 11'd0;
            inside_q     <= 1'b0;
            digit_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            inside_q     <= inside_d;
            digit_q      <= digit_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign InsideRectangle = inside_q;
    assign digit           = digit_q;

endmodule
`default_nettype wire

// File: tb/tb_score_digits_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_digits_controller
//  Purpose  : Directed, self-checking bench; committed scores are queued at
//             load time and compared through the pixel path on each done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_digits_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] scoreIn;
    logic        scoreLoad;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        busy;
    logic        done;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [3:0]  digit;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    score_digits_controller dut (
        .clk             (clk),
        .reset           (reset),
        .scoreIn         (scoreIn),
        .scoreLoad       (scoreLoad),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .busy            (busy),
        .done            (done),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .digit           (digit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference screen: slot s is blanked when the value has no digit at that weight
    function automatic void pix_model(input int x, input int y, input int val,
                                      output int ins, output int ox, output int oy, output int dg);
        int s;
        int p;
        ins = 0; ox = 0; oy = 0; dg = 0;
        if (x >= 16 && x < 144 && y >= 8 && y < 72) begin
            s = (x - 16) / 32;
            p = (s == 0) ? 1000 : (s == 1) ? 100 : (s == 2) ? 10 : 1;
            if (s == 3 || val >= p) begin
                ins = 1;
                ox  = x - 16 - 32 * s;
                oy  = y - 8;
                dg  = (val / p) % 10;
            end
        end
    endfunction

    task automatic check_pix(input string tag, input int x, input int y, input int val);
        int ins, ox, oy, dg;
        pix_model(x, y, val, ins, ox, oy, dg);
        check($sformatf("%s x=%0d y=%0d inside", tag, x, y), InsideRectangle, ins);
        check($sformatf("%s x=%0d y=%0d offsetX", tag, x, y), offsetX, ox);
        check($sformatf("%s x=%0d y=%0d offsetY", tag, x, y), offsetY, oy);
        check($sformatf("%s x=%0d y=%0d digit", tag, x, y), digit, dg);
    endtask

    // Pixel is changed right after the edge so a missing register stage shows up
    task automatic check_slots(input string tag, input int val);
        for (int s = 0; s < 4; s++) begin
            pixelX = 11'(16 + 32 * s + 5);
            pixelY = 11'd18;
            tick();
            pixelX = 11'd0;
            #1;
            check_pix(tag, 16 + 32 * s + 5, 18, val);
        end
    endtask

    task automatic load(input int v, input bit commit, output int t_load);
        scoreIn   = 14'(v);
        scoreLoad = 1'b1;
        t_load    = cyc;
        if (commit) exp_q.push_back((v >= 10000) ? 9999 : v);
        tick();
        scoreLoad = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t_ref, output int val);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " done latency"}, cyc - t_ref, 15);
        val = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    endtask

    initial begin : main
        int t, t2, tc, v, tmp;
        reset     = 1'b1;
        scoreLoad = 1'b0;
        scoreIn   = 14'd0;
        pixelX    = 11'd112;
        pixelY    = 11'd8;
        repeat (3) tick();

        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset inside", InsideRectangle, 0);
        check("reset offsetX", offsetX, 0);
        check("reset offsetY", offsetY, 0);
        check("reset digit", digit, 0);

        reset = 1'b0;
        tick();
        check_pix("post-reset", 112, 8, 0);

        // Exact latency profile for a load from idle
        load(1234, 1'b1, t);
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("1234 busy T+%0d", k), busy, 1);
            check($sformatf("1234 done T+%0d", k), done, (k == 15) ? 1 : 0);
            if (k < 15) tick();
        end
        v = exp_q.pop_front();
        tick();
        check("1234 busy T+16", busy, 0);
        check("1234 done T+16", done, 0);
        check_slots("1234", v);

        load(16383, 1'b1, t);
        wait_done("16383", t, v);
        tick();
        check_slots("16383", v);

        load(0, 1'b1, t);
        wait_done("0", t, v);
        tick();
        check_slots("0", v);

        // Two loads while busy: the later one wins the pending slot
        load(42, 1'b1, t);
        repeat (3) tick();
        load(7, 1'b0, tmp);
        repeat (2) tick();
        load(305, 1'b1, tmp);
        wait_done("42", t, v);
        tc = cyc;
        tick();
        check("b2b busy after commit", busy, 1);
        check("b2b done after commit", done, 0);
        check_slots("42", v);
        wait_done("305", tc, v);
        tick();
        check_slots("305", v);

        // Load in the same cycle as done
        load(100, 1'b1, t);
        wait_done("100", t, v);
        load(200, 1'b1, t2);
        check("load-on-done busy", busy, 1);
        check_slots("100", v);
        wait_done("200", t2, v);
        tick();
        check_slots("200", v);

        load(5678, 1'b1, t);
        wait_done("5678", t, v);
        tick();
        pixelX = 11'd15;
        pixelY = 11'd8;
        for (int x = 15; x <= 145; x++) begin
            tick();
            pixelX = 11'(x + 1);
            #1;
            check_pix("sweep", x, 8, v);
        end
        pixelX = 11'd16;
        pixelY = 11'd71;
        tick();
        pixelY = 11'd72;
        #1;
        check_pix("ybound", 16, 71, v);
        tick();
        pixelY = 11'd8;
        #1;
        check_pix("ybound", 16, 72, v);

        // Reset in the middle of a conversion with a pending value queued
        load(1111, 1'b0, t);
        repeat (2) tick();
        load(2222, 1'b0, tmp);
        repeat (3) tick();
        check("midreset busy before", busy, 1);
        reset = 1'b1;
        tick();
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset inside", InsideRectangle, 0);
        check("midreset offsetX", offsetX, 0);
        check("midreset offsetY", offsetY, 0);
        check("midreset digit", digit, 0);
        reset  = 1'b0;
        pixelX = 11'd112;
        for (int k = 0; k < 30; k++) begin
            tick();
            check($sformatf("midreset no done +%0d", k), done, 0);
            check($sformatf("midreset idle +%0d", k), busy, 0);
        end
        check_slots("after reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_digits_controller.md
# score_digits_controller

Sequencer that turns the game's binary score into four decimal digits and schedules them onto the screen through the digit-bitmap renderer. A multi-cycle double-dabble engine converts each new score, with a one-deep pending buffer for scores that arrive mid-conversion. A double-buffered display register holds the shown digits. A registered pixel-side decoder tells the bitmap renderer which digit to draw, and at what offset, for the current VGA pixel.

## Interface
- TOPLEFT_X, 16: screen X of the left edge of digit slot 0.
- TOPLEFT_Y, 8: screen Y of the top edge of all slots.
- DIGIT_W, 32: slot width in pixels (2x-scaled 16-pixel glyph).
- DIGIT_H, 64: slot height in pixels (2x-scaled 32-pixel glyph).
- BLANK_LEADING, 1: 1 = suppress leading-zero slots.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scoreIn  in  14  binary score.
- scoreLoad  in  1  one-cycle strobe; scoreIn is valid in the same cycle.
- pixelX  in  11  current VGA pixel X.
- pixelY  in  11  current VGA pixel Y.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- offsetX  out  11  pixel X relative to the current slot's left edge.
- offsetY  out  11  pixel Y relative to the slot top.
- InsideRectangle  out  1  the pixel lies in a drawn digit slot.
- digit  out  4  BCD value for the current slot.

## Operation
- Load capture: on scoreLoad, clamp the value: a value of 10000 or more becomes 9999.
  - In IDLE, the clamped value goes to the shift register and the FSM moves to SHIFT.
  - Otherwise the clamped value goes to the pending register and pendValid is set. A later load while busy overwrites the pending value (last wins).
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: waits for a load, or for pendValid.
  - SHIFT: runs exactly 14 cycles, tracked by a 4-bit counter. Each cycle, add 3 to every BCD nibble that is 5 or more, then shift the {BCD, binary} register left by 1.
  - COMMIT: copies the four nibbles into the display register and pulses done.
    - If pendValid is set, load the pending value, clear pendValid and go to SHIFT.
    - Otherwise go to IDLE.
- busy = (state != IDLE).
- A scoreLoad in the COMMIT cycle itself is treated as a pending load. It is serviced immediately because COMMIT checks pending after capture.
- Display register: 4 nibbles; slot 0 (leftmost) is thousands, slot 3 is units. It changes only in COMMIT, so the screen never shows partial conversion values.
- Pixel decode:
  - Slot index = (pixelX - TOPLEFT_X) / DIGIT_W.
  - The pixel is inside when pixelX is in [TOPLEFT_X, TOPLEFT_X + 4*DIGIT_W) and pixelY is in [TOPLEFT_Y, TOPLEFT_Y + DIGIT_H).
  - offsetX = pixelX - TOPLEFT_X - slot*DIGIT_W.
  - offsetY = pixelY - TOPLEFT_Y.
  - DIGIT_W and DIGIT_H must be powers of two (divide = shift).
- Blanking: with BLANK_LEADING = 1, a slot is blanked (InsideRectangle = 0) when it and every slot to its left hold zero. Slot 3 is never blanked.
- Outside the rectangle: InsideRectangle = 0, offsetX = offsetY = 0, digit = 0.

## Timing
- Reset values:
  - state IDLE; counter 0; pendValid 0.
  - Display register all zero, so the screen shows "0".
  - busy, done and InsideRectangle are 0; offsetX, offsetY and digit are 0.
- Conversion latency: with scoreLoad at cycle T (in IDLE), SHIFT runs T+1..T+14, COMMIT is T+15 (done = 1), and new digits drive the pixel path from T+16.
- Back-to-back: a pending score's SHIFT starts the cycle after COMMIT. There is no IDLE gap.
- Pixel path:
  - One register stage: outputs at cycle N+1 reflect pixelX/pixelY at cycle N.
  - The display-register value used is the one held at cycle N.
- Reset mid-conversion: the conversion is abandoned and the pending value dropped. Display returns to 0 on the next edge.
- done and scoreLoad in the same cycle: both are honoured, and the load becomes pending as described above.

## Test plan
- Reset, then load 1234 at cycle T:
  - busy = 1 over T+1..T+15.
  - done = 1 only at T+15.
  - Slots read 1, 2, 3, 4 from T+16.
- Load 16383 → digits 9, 9, 9, 9. Load 0 → only slot 3 is inside and shows 0; slots 0–2 have InsideRectangle = 0.
- Load 42, then load 7 and 305 during busy:
  - First done shows 0042, with slots 0–1 blanked.
  - The second conversion starts the next cycle.
  - Second done shows 305.
  - The 7 is never committed.
- With display holding 5678, sweep pixelX 15..145 at pixelY = 8:
  - X = 15 → outside.
  - X = 16 → slot 0, offsetX 0, digit 5.
  - X = 48 → slot 1, digit 6.
  - X = 143 → slot 3, offsetX 31, digit 8.
  - X = 144 → outside.
  - All outputs lag pixelX by 1 cycle.
- pixelY = 71 → inside, offsetY 63. pixelY = 72 → outside.
- Assert reset at SHIFT cycle 7 with a pending load queued → all outputs return to reset values; no done follows.
